// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache and dcache traffic, one transaction at a time.
// dcache has priority, a starvation streak forces icache through, and a watchdog aborts stuck accesses.
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              busy,
  output logic              timeout_err
);

  // state | meaning
  // IDLE  | no access in flight, arbitrate pending requests
  // IACC  | icache read on the memory port
  // DACC  | dcache read or write on the memory port
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT);
  localparam logic [ST_W-1:0] STREAK_MAX = ST_W'(STARVE_MAX);

  logic [1:0]        r_state;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_ramaddr;
  logic [DATA_W-1:0] r_ramstore;
  logic [ST_W-1:0]   r_streak;
  logic [WD_W-1:0]   r_wdog;
  logic              r_timeout_err;

  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_acc;
  logic w_idone;
  logic w_ddone;
  logic w_abort;

  assign w_dreq    = dREN | dWEN;
  assign w_grant_d = (r_state == IDLE) && w_dreq && (!iREN || (r_streak < STREAK_MAX));
  assign w_grant_i = (r_state == IDLE) && iREN && !w_grant_d;
  assign w_in_acc  = (r_state != IDLE);
  assign w_idone   = (r_state == IACC) && ram_ready;
  assign w_ddone   = (r_state == DACC) && ram_ready;
  // completion wins over the watchdog when both land in the same cycle
  assign w_abort   = w_in_acc && !ram_ready && (r_wdog == WD_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_op_wr       <= 1'b0;
      r_ramaddr     <= '0;
      r_ramstore    <= '0;
      r_streak      <= '0;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_grant_d) begin
            r_state    <= DACC;
            r_ramaddr  <= daddr;
            r_ramstore <= dstore;
            r_op_wr    <= dWEN;
            if (!iREN)
              r_streak <= '0;
            else if (r_streak != STREAK_MAX)
              r_streak <= r_streak + ST_W'(1);
          end else if (w_grant_i) begin
            r_state   <= IACC;
            r_ramaddr <= iaddr;
            r_op_wr   <= 1'b0;
            r_streak  <= '0;
          end
        end
        IACC, DACC: begin
          if (ram_ready || w_abort) begin
            r_state <= IDLE;
            r_wdog  <= '0;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
          if (w_abort)
            r_timeout_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ramREN      = w_in_acc && !r_op_wr;
  assign ramWEN      = w_in_acc && r_op_wr;
  assign ramaddr     = r_ramaddr;
  assign ramstore    = r_ramstore;
  assign busy        = w_in_acc;
  assign timeout_err = r_timeout_err;

  // a requester that dropped its request mid-access sees no data
  assign iwait = iREN && !w_idone;
  assign iload = (w_idone && iREN) ? ramload : '0;
  assign dwait = w_dreq && !w_ddone;
  assign dload = (w_ddone && dREN && !r_op_wr) ? ramload : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single reads, priority, starvation, write-wins,
// watchdog abort and reset during an access.
module tb_cache_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic              CLK;
  logic              nRST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;
  logic              busy;
  logic              timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One transaction with ram_ready already high: grant, complete in the access cycle, back to IDLE.
  task automatic txn_ready(input string tag, input logic [31:0] exp_addr, input bit exp_d,
                           input logic [31:0] load_val);
    ramload = load_val;
    tick();
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_addr"}, 64'(ramaddr), 64'(exp_addr));
    if (exp_d) begin
      check({tag, "_dwait"}, 64'(dwait), 64'd0);
      check({tag, "_dload"}, 64'(dload), 64'(load_val));
      check({tag, "_iwait"}, 64'(iwait), 64'(iREN));
    end else begin
      check({tag, "_iwait"}, 64'(iwait), 64'd0);
      check({tag, "_iload"}, 64'(iload), 64'(load_val));
      check({tag, "_dwait"}, 64'(dwait), 64'd1);
    end
    tick();
    check({tag, "_bubble"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
    #12;
    check("rst_busy",    64'(busy),        64'd0);
    check("rst_ramREN",  64'(ramREN),      64'd0);
    check("rst_ramWEN",  64'(ramWEN),      64'd0);
    check("rst_ramaddr", 64'(ramaddr),     64'd0);
    check("rst_tmo",     64'(timeout_err), 64'd0);
    iREN = 1'b1; dWEN = 1'b1;
    #1;
    check("rst_iwait_comb", 64'(iwait), 64'd1);
    check("rst_dwait_comb", 64'(dwait), 64'd1);
    check("rst_iload",      64'(iload), 64'd0);
    iREN = 1'b0; dWEN = 1'b0;
    tick();
    nRST = 1'b1;

    // single icache read, ready two cycles after grant
    tick();
    iREN = 1'b1; iaddr = 32'h100;
    #1;
    check("i1_idle_iwait", 64'(iwait), 64'd1);
    check("i1_idle_busy",  64'(busy),  64'd0);
    tick();
    check("i1_ramREN",  64'(ramREN),  64'd1);
    check("i1_ramWEN",  64'(ramWEN),  64'd0);
    check("i1_ramaddr", 64'(ramaddr), 64'h100);
    check("i1_iwait_acc", 64'(iwait), 64'd1);
    iaddr = 32'h999;
    tick();
    check("i1_addr_held", 64'(ramaddr), 64'h100);
    ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    #1;
    check("i1_iwait_done", 64'(iwait), 64'd0);
    check("i1_iload",      64'(iload), 64'hDEADBEEF);
    tick();
    iREN = 1'b0; ram_ready = 1'b0;
    #1;
    check("i1_after_busy",  64'(busy),  64'd0);
    check("i1_after_iload", 64'(iload), 64'd0);

    // simultaneous icache read and dcache write: write first, bubble, then read
    iREN = 1'b1; iaddr = 32'h140;
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hCAFEF00D;
    tick();
    check("dw_ramWEN",   64'(ramWEN),   64'd1);
    check("dw_ramREN",   64'(ramREN),   64'd0);
    check("dw_ramaddr",  64'(ramaddr),  64'h200);
    check("dw_ramstore", 64'(ramstore), 64'hCAFEF00D);
    check("dw_iwait",    64'(iwait),    64'd1);
    ram_ready = 1'b1;
    #1;
    check("dw_dwait_done", 64'(dwait), 64'd0);
    check("dw_iwait_done", 64'(iwait), 64'd1);
    tick();
    dWEN = 1'b0; ram_ready = 1'b0;
    #1;
    check("dw_bubble", 64'(busy),   64'd0);
    check("dw_bub_en", 64'(ramREN | ramWEN), 64'd0);
    tick();
    check("ir_ramREN",  64'(ramREN),  64'd1);
    check("ir_ramaddr", 64'(ramaddr), 64'h140);
    ram_ready = 1'b1; ramload = 32'h12345678;
    #1;
    check("ir_iload", 64'(iload), 64'h12345678);
    tick();
    iREN = 1'b0; ram_ready = 1'b0;

    // starvation: both held, grants D,D,D,D,I then D again
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400; ram_ready = 1'b1;
    txn_ready("st_g1", 32'h400, 1'b1, 32'h55AA0001);
    txn_ready("st_g2", 32'h400, 1'b1, 32'h55AA0002);
    txn_ready("st_g3", 32'h400, 1'b1, 32'h55AA0003);
    txn_ready("st_g4", 32'h400, 1'b1, 32'h55AA0004);
    txn_ready("st_g5", 32'h300, 1'b0, 32'h55AA0005);
    txn_ready("st_g6", 32'h400, 1'b1, 32'h55AA0006);
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;

    // dREN and dWEN together: write wins, no load data
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = 32'h11112222;
    tick();
    check("rw_ramWEN",   64'(ramWEN),   64'd1);
    check("rw_ramREN",   64'(ramREN),   64'd0);
    check("rw_ramstore", 64'(ramstore), 64'h11112222);
    ram_ready = 1'b1; ramload = 32'hFFFF0000;
    #1;
    check("rw_dwait", 64'(dwait), 64'd0);
    check("rw_dload", 64'(dload), 64'd0);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;

    // watchdog: access cycles with wdog 0..TIMEOUT, then abort
    dREN = 1'b1; daddr = 32'h600;
    tick();
    check("to_in_acc", 64'(busy),        64'd1);
    check("to_err0",   64'(timeout_err), 64'd0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    check("to_cycles", 64'(cyc),         64'(TIMEOUT + 1));
    check("to_err1",   64'(timeout_err), 64'd1);
    check("to_dwait",  64'(dwait),       64'd1);
    check("to_ramREN", 64'(ramREN),      64'd0);
    dREN = 1'b0;
    tick();
    tick();
    check("to_sticky", 64'(timeout_err), 64'd1);

    // reset during DACC with a streak built up, then resume
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h700; ram_ready = 1'b1;
    txn_ready("pr_g1", 32'h700, 1'b1, 32'h00000001);
    txn_ready("pr_g2", 32'h700, 1'b1, 32'h00000002);
    txn_ready("pr_g3", 32'h700, 1'b1, 32'h00000003);
    ram_ready = 1'b0;
    tick();
    check("pr_g4_dacc", 64'(ramREN),  64'd1);
    check("pr_g4_addr", 64'(ramaddr), 64'h700);
    nRST = 1'b0;
    #1;
    check("ar_ramREN", 64'(ramREN),      64'd0);
    check("ar_ramWEN", 64'(ramWEN),      64'd0);
    check("ar_busy",   64'(busy),        64'd0);
    check("ar_tmo",    64'(timeout_err), 64'd0);
    tick();
    nRST = 1'b1;
    ram_ready = 1'b1;
    txn_ready("ar_g1", 32'h700, 1'b1, 32'h00000011);
    txn_ready("ar_g2", 32'h700, 1'b1, 32'h00000012);
    txn_ready("ar_g3", 32'h700, 1'b1, 32'h00000013);
    txn_ready("ar_g4", 32'h700, 1'b1, 32'h00000014);
    txn_ready("ar_g5", 32'h300, 1'b0, 32'h00000015);
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "bench time limit");
  end
endmodule
